uart_ctrl: RTL

Second-generation memory-mapped UART peripheral on the CCX memory bus. It has internal TX and RX engines with a runtime-programmable bit divisor. Parametrised TX and RX FIFOs provide threshold and empty interrupts. Sticky overrun, framing and break error flags are write-1-to-clear, and an internal loopback mode is provided. It replaces the fixed-rate UART top level in the SoC peripheral region.

---
 rtl/uart_ctrl_if.sv | 14 +
 rtl/uart_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ctrl_if.sv
// CCX memory-bus port bundle: REQ is the bus master view, RSP the slave view.
interface scarv_ccx_memif;
    logic        req;
    logic        gnt;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    logic        error;

    modport REQ (output req, wen, addr, wdata, strb, input gnt, rdata, error);
    modport RSP (input req, wen, addr, wdata, strb, output gnt, rdata, error);
endinterface

// File: rtl/uart_ctrl.sv
// Memory-mapped UART: programmable divisor, TX/RX byte FIFOs, sticky W1C error flags
// and internal loopback.
module uart_ctrl_fifo #(
    parameter int DEPTH = 8,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          g_clk,
    input  logic          g_resetn,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic [LW-1:0] level,
    output logic          empty,
    output logic          full
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == LW'(DEPTH));
    assign level = cnt_q;
    assign dout  = mem_q[rp_q];

    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        mem_d   = mem_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        if (do_push) begin
            mem_d[wp_q] = din;
            wp_d        = wp_q + AW'(1);
        end
        if (do_pop) rp_d = rp_q + AW'(1);
        cnt_d = cnt_q + LW'(do_push) - LW'(do_pop);
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge g_clk) mem_q <= mem_d;
endmodule

// state | meaning (same encoding for both engines)
// IDLE  | waiting: TX for FIFO data with tx_en, RX for a falling edge with rx_en
// START | start bit; RX waits half a bit then rejects glitches
// DATA  | 8 data bits, LSB first
// STOP  | stop bit(s); RX also holds here after a break until the line is high
module uart_ctrl #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BIT_RATE   = 256_000,
    parameter int FIFO_DEPTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int DIV_W      = 16
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    output logic            g_clk_req,
    input  logic            uart_rxd,
    output logic            uart_txd,
    output logic            irq,
    scarv_ccx_memif.RSP     memif
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(CLK_HZ / BIT_RATE - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [11:0]      ctrl_q, ctrl_d;
    logic [DIV_W-1:0] div_q, div_d, div_eff, rx_half;
    logic [2:0]       err_q, err_d;
    logic [31:0]      rdata_q, rdata_d, stat;
    logic             error_q, error_d, irq_q, irq_d;

    state_t           tx_st_q, tx_st_d, rx_st_q, rx_st_d;
    logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [7:0]       tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic [2:0]       tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d, rx_sync_q, rx_sync_d;
    logic             tx_stop_q, tx_stop_d, tx_line_q, tx_line_d, tx_pop, tx_load, tx_go;
    logic             rx_stop_q, rx_stop_d, rx_ok_q, rx_ok_d, rx_brk_q, rx_brk_d;
    logic             rx_push_q, rx_push_d, rx_brk_set, rx_frm_set, rx_ovr_set;
    logic             rx_line, rx_fall, rx_tc;

    logic [7:0]       tx_head, rx_head;
    logic [LW-1:0]    tx_level, rx_level;
    logic             tx_empty, tx_full, rx_empty, rx_full;

    logic [4:0] a;
    logic       sel_rx, sel_tx, sel_stat, sel_ctrl, sel_div, addr_ok, acc_rd, acc_wr, rx_pop, tx_push;
    logic       unused_ok;

    assign a        = memif.addr[4:0];
    assign sel_rx   = (a == 5'h00);
    assign sel_tx   = (a == 5'h04);
    assign sel_stat = (a == 5'h08);
    assign sel_ctrl = (a == 5'h0C);
    assign sel_div  = (a == 5'h10);
    assign addr_ok  = sel_rx | sel_tx | sel_stat | sel_ctrl | sel_div;
    assign acc_rd   = memif.req & ~memif.wen;
    assign acc_wr   = memif.req & memif.wen & memif.strb[0];
    assign rx_pop   = acc_rd & sel_rx;
    assign tx_push  = acc_wr & sel_tx;
    assign unused_ok = ^{memif.addr, memif.wdata, memif.strb, tx_level};

    // Divisors below 3 leave no room for the half-bit RX alignment.
    assign div_eff = (div_q < DIV_W'(3)) ? DIV_W'(3) : div_q;
    assign rx_half = DIV_W'(({1'b0, div_eff} + (DIV_W+1)'(1)) >> 1) - DIV_W'(1);

    uart_ctrl_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .g_clk(g_clk), .g_resetn(g_resetn), .push(tx_push), .pop(tx_pop), .din(memif.wdata[7:0]),
        .dout(tx_head), .level(tx_level), .empty(tx_empty), .full(tx_full));
    uart_ctrl_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .g_clk(g_clk), .g_resetn(g_resetn), .push(rx_push_q), .pop(rx_pop), .din(rx_sh_q),
        .dout(rx_head), .level(rx_level), .empty(rx_empty), .full(rx_full));

    assign stat       = {24'b0, err_q, (tx_st_q != S_IDLE), tx_full, tx_empty, rx_full, ~rx_empty};
    assign rx_ovr_set = rx_push_q & rx_full & ~rx_pop;
    assign memif.gnt   = 1'b1;
    assign memif.rdata = rdata_q;
    assign memif.error = error_q;
    assign irq         = irq_q;
    assign uart_txd    = tx_line_q | ctrl_q[2];
    assign g_clk_req   = memif.req | (tx_st_q != S_IDLE) | ~tx_empty | (rx_st_q != S_IDLE) | irq_q;

    always_comb begin
        ctrl_d  = ctrl_q;
        div_d   = div_q;
        rdata_d = rdata_q;
        error_d = error_q;
        err_d   = (err_q & ~((acc_wr & sel_stat) ? memif.wdata[7:5] : 3'b0))
                | {rx_brk_set, rx_frm_set, rx_ovr_set};
        if (acc_wr & sel_ctrl) ctrl_d = memif.wdata[11:0] & 12'hF3F;
        if (acc_wr & sel_div)  div_d  = memif.wdata[DIV_W-1:0];
        if (memif.req) begin
            error_d = ~addr_ok | (tx_push & tx_full & ~tx_pop);
            rdata_d = '0;
            if (!memif.wen) begin
                if (sel_rx & ~rx_empty) rdata_d = {24'b0, rx_head};
                else if (sel_stat)      rdata_d = stat;
                else if (sel_ctrl)      rdata_d = {20'b0, ctrl_q};
                else if (sel_div)       rdata_d = 32'(div_q);
            end
        end
        irq_d = (ctrl_q[3] & (32'(rx_level) >= 32'(ctrl_q[11:8])) & (rx_level != '0))
              | (ctrl_q[4] & tx_empty) | (ctrl_q[5] & (|err_q));
    end

    assign tx_go = ctrl_q[0] & ~tx_empty;

    always_comb begin
        tx_st_d   = tx_st_q;
        tx_cnt_d  = tx_cnt_q;
        tx_div_d  = tx_div_q;
        tx_sh_d   = tx_sh_q;
        tx_bit_d  = tx_bit_q;
        tx_stop_d = tx_stop_q;
        tx_line_d = tx_line_q;
        tx_pop    = 1'b0;
        tx_load   = 1'b0;
        if (tx_st_q == S_IDLE) begin
            tx_load = tx_go;
        end else if (tx_cnt_q != '0) begin
            tx_cnt_d = tx_cnt_q - DIV_W'(1);
        end else begin
            tx_cnt_d = tx_div_q;
            case (tx_st_q)
                S_START: begin
                    tx_st_d   = S_DATA;
                    tx_line_d = tx_sh_q[0];
                    tx_bit_d  = '0;
                end
                S_DATA: begin
                    if (tx_bit_q == 3'd7) begin
                        tx_st_d   = S_STOP;
                        tx_line_d = 1'b1;
                        tx_stop_d = 1'b0;
                    end else begin
                        tx_sh_d   = tx_sh_q >> 1;
                        tx_line_d = tx_sh_q[1];
                        tx_bit_d  = tx_bit_q + 3'd1;
                    end
                end
                S_STOP: begin
                    if (tx_stop_q == 1'(STOP_BITS - 1)) begin
                        tx_st_d = S_IDLE;
                        tx_load = tx_go;   // chain straight into the next frame
                    end else begin
                        tx_stop_d = 1'b1;
                    end
                end
                default: tx_st_d = S_IDLE;
            endcase
        end
        if (tx_load) begin
            tx_pop    = 1'b1;
            tx_st_d   = S_START;
            tx_sh_d   = tx_head;
            tx_div_d  = div_eff;
            tx_cnt_d  = div_eff;
            tx_line_d = 1'b0;
        end
    end

    assign rx_line = rx_sync_q[1];
    assign rx_fall = rx_sync_q[2] & ~rx_sync_q[1];
    assign rx_tc   = (rx_cnt_q == '0);

    always_comb begin
        rx_sync_d  = {rx_sync_q[1:0], ctrl_q[2] ? tx_line_q : uart_rxd};
        rx_st_d    = rx_st_q;
        rx_cnt_d   = rx_cnt_q;
        rx_div_d   = rx_div_q;
        rx_sh_d    = rx_sh_q;
        rx_bit_d   = rx_bit_q;
        rx_stop_d  = rx_stop_q;
        rx_ok_d    = rx_ok_q;
        rx_brk_d   = rx_brk_q;
        rx_push_d  = 1'b0;
        rx_brk_set = 1'b0;
        rx_frm_set = 1'b0;
        if (rx_st_q != S_IDLE && !rx_tc) rx_cnt_d = rx_cnt_q - DIV_W'(1);
        case (rx_st_q)
            S_IDLE: begin
                if (ctrl_q[1] & rx_fall) begin
                    rx_st_d  = S_START;
                    rx_div_d = div_eff;
                    rx_cnt_d = rx_half;
                end
            end
            S_START: begin
                if (rx_tc) begin
                    rx_st_d  = rx_line ? S_IDLE : S_DATA;
                    rx_cnt_d = rx_div_q;
                    rx_bit_d = '0;
                end
            end
            S_DATA: begin
                if (rx_tc) begin
                    rx_sh_d  = {rx_line, rx_sh_q[7:1]};
                    rx_cnt_d = rx_div_q;
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_st_d   = S_STOP;
                        rx_stop_d = 1'b0;
                        rx_ok_d   = 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (rx_brk_q) begin
                    if (rx_line) begin
                        rx_brk_d = 1'b0;
                        rx_st_d  = S_IDLE;
                    end
                end else if (rx_tc) begin
                    rx_cnt_d = rx_div_q;
                    if (rx_stop_q == 1'(STOP_BITS - 1)) begin
                        rx_st_d = S_IDLE;
                        if (rx_ok_q & rx_line) begin
                            rx_push_d = 1'b1;
                        end else if (rx_sh_q == 8'h00) begin
                            rx_brk_set = 1'b1;
                            rx_brk_d   = 1'b1;
                            rx_st_d    = S_STOP;
                        end else begin
                            rx_frm_set = 1'b1;
                        end
                    end else begin
                        rx_stop_d = 1'b1;
                        rx_ok_d   = rx_ok_q & rx_line;
                    end
                end
            end
            default: rx_st_d = S_IDLE;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            ctrl_q    <= 12'h103;
            div_q     <= DIV_RST;
            err_q     <= '0;
            rdata_q   <= '0;
            error_q   <= 1'b0;
            irq_q     <= 1'b0;
            tx_st_q   <= S_IDLE;
            tx_cnt_q  <= '0;
            tx_div_q  <= '0;
            tx_sh_q   <= '0;
            tx_bit_q  <= '0;
            tx_stop_q <= 1'b0;
            tx_line_q <= 1'b1;
            rx_sync_q <= 3'b111;
            rx_st_q   <= S_IDLE;
            rx_cnt_q  <= '0;
            rx_div_q  <= '0;
            rx_sh_q   <= '0;
            rx_bit_q  <= '0;
            rx_stop_q <= 1'b0;
            rx_ok_q   <= 1'b0;
            rx_brk_q  <= 1'b0;
            rx_push_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            div_q     <= div_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            error_q   <= error_d;
            irq_q     <= irq_d;
            tx_st_q   <= tx_st_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_div_q  <= tx_div_d;
            tx_sh_q   <= tx_sh_d;
            tx_bit_q  <= tx_bit_d;
            tx_stop_q <= tx_stop_d;
            tx_line_q <= tx_line_d;
            rx_sync_q <= rx_sync_d;
            rx_st_q   <= rx_st_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_div_q  <= rx_div_d;
            rx_sh_q   <= rx_sh_d;
            rx_bit_q  <= rx_bit_d;
            rx_stop_q <= rx_stop_d;
            rx_ok_q   <= rx_ok_d;
            rx_brk_q  <= rx_brk_d;
            rx_push_q <= rx_push_d;
        end
    end
endmodule
